pipe_hazard_unit: RTL and testbench

Parametrised RAW-hazard and control-flush unit for the 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks destination registers of in-flight instructions in a tag shift register and stalls ID while a source operand is still pending. It converts a taken branch or jump resolved in EX into a flush of IF/ID and a bubble into EX. The pipeline runs today with hold tied low; this block drives the PC hold, IF/ID hold and ID/EX bubble controls and adds stall and flush statistics.

---
 rtl/pipe_hazard_unit.sv | 101 ++++++++++
 tb/tb_pipe_hazard_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// RAW-hazard stall and branch-flush control for the 5-stage pipe; tracks in-flight destinations in a tag shift register.
// stall/flush_id/ex_bubble are combinational (0 cycles); slots and counters update on posedge clk; stall holds PC and IF/ID.
module pipe_hazard_unit #(
    parameter int AW        = 4,
    parameter int DEPTH     = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_rs_en,
    input  logic                 id_rt_en,
    input  logic [AW-1:0]        id_rs_addr,
    input  logic [AW-1:0]        id_rt_addr,
    input  logic                 id_wr_en,
    input  logic [AW-1:0]        id_wr_addr,
    input  logic                 ex_redirect,
    input  logic                 cnt_clr,
    output logic                 stall,
    output logic                 flush_id,
    output logic                 ex_bubble,
    output logic [(1<<AW)-1:0]   busy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // With write-before-read in the register file the WB slot is already visible to ID.
    localparam int HZ = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0] slot_v_q, slot_v_d;
    logic [AW-1:0]    slot_addr_q [DEPTH];
    logic [AW-1:0]    slot_addr_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             match_s, match_t, load;

    always_comb begin
        match_s = 1'b0;
        match_t = 1'b0;
        for (int k = 0; k < HZ; k++) begin
            if (slot_v_q[k] && (slot_addr_q[k] == id_rs_addr)) match_s = 1'b1;
            if (slot_v_q[k] && (slot_addr_q[k] == id_rt_addr)) match_t = 1'b1;
        end
        match_s = match_s & id_rs_en & (id_rs_addr != '0);
        match_t = match_t & id_rt_en & (id_rt_addr != '0);
    end

    assign stall     = id_valid & (match_s | match_t) & ~ex_redirect;
    assign flush_id  = ex_redirect;
    assign ex_bubble = stall | ex_redirect | ~id_valid;
    assign load      = id_valid & id_wr_en & (id_wr_addr != '0) & ~stall & ~ex_redirect;

    always_comb begin
        busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_v_q[k]) busy[slot_addr_q[k]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_comb begin
        slot_v_d[0]    = load;
        slot_addr_d[0] = id_wr_addr;
        for (int k = 1; k < DEPTH; k++) begin
            slot_v_d[k]    = slot_v_q[k-1];
            slot_addr_d[k] = slot_addr_q[k-1];
        end
    end

    // Counters saturate at all-ones; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) slot_addr_q[k] <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int k = 0; k < DEPTH; k++) slot_addr_q[k] <= slot_addr_d[k];
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: config A (bypass, 4-bit counters) and config B (no bypass) share one stimulus stream.
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        id_valid, id_rs_en, id_rt_en, id_wr_en, ex_redirect, cnt_clr;
    logic [3:0]  id_rs_addr, id_rt_addr, id_wr_addr;
    logic        stall_a, flush_a, bub_a, stall_b, flush_b, bub_b;
    logic [15:0] busy_a, busy_b;
    logic [3:0]  scnt_a, fcnt_a;
    logic [15:0] scnt_b, fcnt_b;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_unit #(.AW(4), .DEPTH(3), .WB_BYPASS(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .ex_redirect(ex_redirect), .cnt_clr(cnt_clr), .stall(stall_a), .flush_id(flush_a),
        .ex_bubble(bub_a), .busy(busy_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

    pipe_hazard_unit #(.AW(4), .DEPTH(3), .WB_BYPASS(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .ex_redirect(ex_redirect), .cnt_clr(cnt_clr), .stall(stall_b), .flush_id(flush_b),
        .ex_bubble(bub_b), .busy(busy_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

    // Reference model: per register, cycles elapsed since its youngest write entered EX.
    int          age [2][16];
    logic [31:0] sc [2];
    logic [31:0] fc [2];

    function automatic int hz_of(int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] max_of(int c);
        return (c == 0) ? 32'd15 : 32'd65535;
    endfunction

    function automatic bit m_haz(int c, logic [3:0] r);
        return (r != 4'd0) && (age[c][r] < hz_of(c));
    endfunction

    function automatic bit m_stall(int c);
        return id_valid && ((id_rs_en && m_haz(c, id_rs_addr)) || (id_rt_en && m_haz(c, id_rt_addr)))
               && !ex_redirect;
    endfunction

    function automatic logic [15:0] m_busy(int c);
        logic [15:0] b;
        b = '0;
        for (int r = 1; r < 16; r++) if (age[c][r] < 3) b[r] = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 16; r++) age[c][r] = 100;
            sc[c] = 0;
            fc[c] = 0;
        end
    endtask

    // Advance one clock: sample inputs, wait for the edge, update the model, return at negedge.
    task automatic tick();
        bit st [2];
        bit ld [2];
        logic [3:0] wa;
        bit clr, rdr;
        for (int c = 0; c < 2; c++) begin
            st[c] = m_stall(c);
            ld[c] = id_valid && id_wr_en && (id_wr_addr != 4'd0) && !st[c] && !ex_redirect;
        end
        wa  = id_wr_addr;
        clr = cnt_clr;
        rdr = ex_redirect;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 16; r++) if (age[c][r] < 100) age[c][r]++;
                if (ld[c]) age[c][wa] = 0;
                if (clr) begin
                    sc[c] = 0;
                    fc[c] = 0;
                end else begin
                    if (st[c] && sc[c] < max_of(c)) sc[c]++;
                    if (rdr && fc[c] < max_of(c)) fc[c]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs_en = 0; id_rt_en = 0; id_wr_en = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_wr_addr = 0;
        ex_redirect = 0; cnt_clr = 0;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic clear_counters();
        idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        id_valid = 1; id_rs_en = 1; id_rs_addr = 3;
        tick();
        #1;
        checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b/%b expected 0/0", stall_a, stall_b); end
        checks++; if (busy_a !== 16'h0 || busy_b !== 16'h0) begin failures++; $display("FAIL reset_busy: got %h/%h expected 0/0", busy_a, busy_b); end
        checks++; if (scnt_a !== 4'd0 || fcnt_a !== 4'd0 || scnt_b !== 16'd0 || fcnt_b !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d %0d %0d %0d expected 0", scnt_a, fcnt_a, scnt_b, fcnt_b); end
        ex_redirect = 1;
        #1;
        checks++; if (flush_a !== 1'b1 || flush_b !== 1'b1) begin failures++; $display("FAIL reset_flush: got %b/%b expected 1/1", flush_a, flush_b); end
        idle();
        @(negedge clk);
        rst = 0;
        id_valid = 1; id_rs_en = 1; id_rs_addr = 3;
        tick();
        tick();
        #1;
        checks++; if (stall_a !== 1'b0 || busy_a !== 16'h0 || scnt_a !== 4'd0 || fcnt_b !== 16'd0) begin failures++; $display("FAIL post_reset: got stall=%b busy=%h scnt=%0d fcnt=%0d expected 0", stall_a, busy_a, scnt_a, fcnt_b); end
        idle();
    endtask

    task automatic test_back_to_back();
        bit exp_sa [4] = '{1, 1, 0, 0};
        bit exp_sb [4] = '{1, 1, 1, 0};
        bit exp_bz [4] = '{1, 1, 1, 0};
        clear_counters();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 3;
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL b2b_producer_stall: got %b expected 0", stall_a); end
        tick();
        id_wr_en = 0; id_rs_en = 1; id_rs_addr = 3;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (stall_a !== exp_sa[i] || bub_a !== exp_sa[i]) begin failures++; $display("FAIL b2b_stall_a cyc%0d: got stall=%b bubble=%b expected %b", i + 1, stall_a, bub_a, exp_sa[i]); end
            checks++; if (stall_b !== exp_sb[i]) begin failures++; $display("FAIL b2b_stall_b cyc%0d: got %b expected %b", i + 1, stall_b, exp_sb[i]); end
            checks++; if (busy_a[3] !== exp_bz[i] || busy_b[3] !== exp_bz[i]) begin failures++; $display("FAIL b2b_busy3 cyc%0d: got %b/%b expected %b", i + 1, busy_a[3], busy_b[3], exp_bz[i]); end
            tick();
        end
        checks++; if (scnt_a !== 4'd2) begin failures++; $display("FAIL b2b_cnt_a: got %0d expected 2", scnt_a); end
        checks++; if (scnt_b !== 16'd3) begin failures++; $display("FAIL b2b_cnt_b: got %0d expected 3", scnt_b); end
        drain();
    endtask

    task automatic test_reg0();
        bit seen = 0;
        id_valid = 1; id_wr_en = 1; id_wr_addr = 0;
        tick();
        id_wr_en = 0; id_rs_en = 1; id_rt_en = 1; id_rs_addr = 0; id_rt_addr = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall_a || stall_b || busy_a != 0 || busy_b != 0) seen = 1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reg0: got stall/busy activity=%b expected 0", seen); end
        drain();
    endtask

    task automatic test_redirect();
        clear_counters();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 5;
        tick();
        id_rs_en = 1; id_rs_addr = 5; id_wr_addr = 6; ex_redirect = 1;
        #1;
        checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failures++; $display("FAIL redir_stall: got %b/%b expected 0/0", stall_a, stall_b); end
        checks++; if (flush_a !== 1'b1 || bub_a !== 1'b1 || bub_b !== 1'b1) begin failures++; $display("FAIL redir_flush: got flush=%b bubble=%b/%b expected 1", flush_a, bub_a, bub_b); end
        tick();
        idle();
        #1;
        checks++; if (fcnt_a !== 4'd1 || fcnt_b !== 16'd1 || scnt_a !== 4'd0 || scnt_b !== 16'd0) begin failures++; $display("FAIL redir_cnt: got f=%0d/%0d s=%0d/%0d expected f=1 s=0", fcnt_a, fcnt_b, scnt_a, scnt_b); end
        checks++; if (busy_a[6] !== 1'b0 || busy_b[6] !== 1'b0 || busy_a[5] !== 1'b1) begin failures++; $display("FAIL redir_slot0: got busy_a=%h busy_b=%h expected r6 clear, r5 set", busy_a, busy_b); end
        drain();
    endtask

    task automatic test_saturation();
        clear_counters();
        for (int k = 1; k <= 10; k++) begin
            id_valid = 1; id_wr_en = 1; id_wr_addr = 4'(k); id_rs_en = 0;
            tick();
            id_wr_en = 0; id_rs_en = 1; id_rs_addr = 4'(k);
            repeat (3) tick();
        end
        idle();
        #1;
        checks++; if (scnt_a !== 4'd15) begin failures++; $display("FAIL sat_a: got %0d expected 15", scnt_a); end
        checks++; if (scnt_b !== 16'd30) begin failures++; $display("FAIL sat_b: got %0d expected 30", scnt_b); end
        drain();
        clear_counters();
        #1;
        checks++; if (scnt_a !== 4'd0 || scnt_b !== 16'd0) begin failures++; $display("FAIL clr: got %0d/%0d expected 0", scnt_a, scnt_b); end
        id_valid = 1; id_wr_en = 1; id_wr_addr = 7;
        tick();
        id_wr_en = 0; id_rs_en = 1; id_rs_addr = 7; cnt_clr = 1;
        #1;
        checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL clr_stall_pre: got %b expected 1", stall_a); end
        tick();
        cnt_clr = 0;
        #1;
        checks++; if (scnt_a !== 4'd0 || scnt_b !== 16'd0) begin failures++; $display("FAIL clr_vs_stall: got %0d/%0d expected 0", scnt_a, scnt_b); end
        tick();
        checks++; if (scnt_a !== 4'd1) begin failures++; $display("FAIL clr_then_count: got %0d expected 1", scnt_a); end
        drain();
    endtask

    task automatic test_async_reset();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 7;
        tick();
        id_wr_en = 0; id_rs_en = 1; id_rs_addr = 7;
        #1;
        checks++; if (stall_a !== 1'b1 || busy_a[7] !== 1'b1) begin failures++; $display("FAIL arst_pre: got stall=%b busy7=%b expected 1/1", stall_a, busy_a[7]); end
        rst = 1;
        #1;
        checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0 || busy_a !== 16'h0 || busy_b !== 16'h0) begin failures++; $display("FAIL arst_immediate: got stall=%b/%b busy=%h/%h expected 0", stall_a, stall_b, busy_a, busy_b); end
        model_reset();
        tick();
        rst = 0;
        #1;
        checks++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin failures++; $display("FAIL arst_resume: got %b/%b expected 0/0", stall_a, stall_b); end
        tick();
        drain();
    endtask

    task automatic test_random();
        logic        o_st, o_fl, o_bu;
        logic [15:0] o_busy;
        logic [31:0] o_sc, o_fc;
        bit          e_st;
        for (int n = 0; n < 400; n++) begin
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rs_en    = $urandom_range(0, 1);
            id_rt_en    = $urandom_range(0, 1);
            id_wr_en    = $urandom_range(0, 1);
            id_rs_addr  = 4'($urandom_range(0, 7));
            id_rt_addr  = 4'($urandom_range(0, 7));
            id_wr_addr  = 4'($urandom_range(0, 7));
            ex_redirect = ($urandom_range(0, 7) == 0);
            cnt_clr     = ($urandom_range(0, 63) == 0);
            #1;
            for (int c = 0; c < 2; c++) begin
                o_st   = (c == 0) ? stall_a : stall_b;
                o_fl   = (c == 0) ? flush_a : flush_b;
                o_bu   = (c == 0) ? bub_a : bub_b;
                o_busy = (c == 0) ? busy_a : busy_b;
                o_sc   = (c == 0) ? {28'b0, scnt_a} : {16'b0, scnt_b};
                o_fc   = (c == 0) ? {28'b0, fcnt_a} : {16'b0, fcnt_b};
                e_st   = m_stall(c);
                checks++; if (o_st !== e_st) begin failures++; $display("FAIL rnd_stall cfg%0d n%0d: got %b expected %b", c, n, o_st, e_st); end
                checks++; if (o_fl !== ex_redirect) begin failures++; $display("FAIL rnd_flush cfg%0d n%0d: got %b expected %b", c, n, o_fl, ex_redirect); end
                checks++; if (o_bu !== (e_st | ex_redirect | ~id_valid)) begin failures++; $display("FAIL rnd_bubble cfg%0d n%0d: got %b expected %b", c, n, o_bu, e_st | ex_redirect | ~id_valid); end
                checks++; if (o_busy !== m_busy(c)) begin failures++; $display("FAIL rnd_busy cfg%0d n%0d: got %h expected %h", c, n, o_busy, m_busy(c)); end
                checks++; if (o_sc !== sc[c] || o_fc !== fc[c]) begin failures++; $display("FAIL rnd_cnt cfg%0d n%0d: got s=%0d f=%0d expected s=%0d f=%0d", c, n, o_sc, o_fc, sc[c], fc[c]); end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1;
        test_reset();
        test_back_to_back();
        test_reg0();
        test_redirect();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
